instruction_sequencer: RTL and testbench
========================================

Name: instruction_sequencer

Overview:
- Multi-cycle controller for the 16-bit datapath: register bank, operand mux, A/G registers, ALU, immediate extensor.
- Latches the 9-bit instruction field from iin.
- Steps a T0..T3 state machine and drives all datapath write enables, mux selects and ALU opcode, with a run/done handshake to the instruction source.
- Replaces the free-running 2-bit step counter with a state machine decoded per opcode.

Parameters:
- NREGS, 8: number of general registers; one-hot write-enable width.
- WIDTH, 16: datapath and instruction width.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clock  input  1  rising-edge clock.
- resetn  input  1  asynchronous active-low reset.
- run  input  1  request to execute the instruction on iin.
- iin  input  WIDTH  instruction word: [15:13] opcode, [12:10] rx, [9:7] ry, [6:0] immediate (extended by extensor).
- ir  output  9  latched iin[15:7].
- reg_wr  output  NREGS  one-hot register-bank write enable.
- mux_sel  output  4  operand mux select: 0-7 = R0-R7, 8 = extended immediate, 9 = G, 15 = none.
- ext_en  output  1  extensor enable; the extensor captures iin[6:0] during fetch.
- a_load  output  1  load A register from mux.
- g_load  output  1  load G register from ALU.
- alu_op  output  3  ALU opcode: equals ir[8:6] for ALU instructions, 0 otherwise.
- done  output  1  instruction complete, one-cycle pulse.
- illegal  output  1  one-cycle pulse on a reserved opcode.
- retired  output  CNT_W  count of completed legal instructions.

Behaviour:
- States: IDLE (T0), T1, T2, T3. Two-bit state register; outputs are combinational from state and ir.
- Reset: asynchronous on resetn=0.
  - state=IDLE, ir=0, retired=0.
  - reg_wr=0, mux_sel=15, ext_en=a_load=g_load=done=illegal=0, alu_op=0.
  - Reset mid-instruction aborts it: no register write, no done.
- IDLE:
  - run=0: stay in IDLE, all enables 0.
  - run=1: ext_en=1; on the edge, ir<=iin[15:7]; go to T1.
  - run is sampled only in IDLE and ignored in T1-T3.
- T1, decoded on ir[8:6]:
  - 000 mv: mux_sel=ry, reg_wr[rx]=1, done=1 -> IDLE.
  - 001 mvi: mux_sel=8, reg_wr[rx]=1, done=1 -> IDLE.
  - 010 add, 011 sub, 100 and, 101 or, 110 slt: mux_sel=rx, a_load=1 -> T2.
  - 111 reserved: done=1, illegal=1, no write, retired unchanged -> IDLE.
- T2 (ALU ops only): mux_sel=ry, alu_op=ir[8:6], g_load=1 -> T3.
- T3: mux_sel=9, reg_wr[rx]=1, done=1 -> IDLE.
- Latency from the run-sampling edge to the done cycle:
  - mv/mvi: done during the cycle after fetch (2 cycles total).
  - ALU ops: 4 cycles total.
- Back-to-back: if run is still high in the IDLE cycle after done, the next fetch occurs on that edge. Throughput is one instruction per 2 or 4 cycles.
- reg_wr is always one-hot or zero; never more than one bit set.
- rx=ry is legal: mv R3,R3 writes R3 with itself; add R2,R2 doubles R2.
- retired increments by 1 on the edge ending each done cycle with illegal=0. It wraps from 2^CNT_W-1 to 0 with no flag.
- iin may change freely after the fetch edge; only ir is used after fetch.

Test Plan:
- Reset: resetn=0 mid-T2 of add -> state IDLE immediately; reg_wr=0, mux_sel=15, retired=0; no done afterward.
- mvi R5 (iin=16'h3405), run pulse -> edge 1: ir=9'h068; T1: mux_sel=8, reg_wr=8'h20, done=1; retired=1.
- add R1,R2 (iin=16'h4500), run held high:
  - T1: mux_sel=1, a_load=1.
  - T2: mux_sel=2, g_load=1, alu_op=2.
  - T3: mux_sel=9, reg_wr=8'h02, done=1.
  - Next fetch on the following edge.
- Reserved opcode (iin=16'hE000) -> T1: done=1, illegal=1, reg_wr=0; retired unchanged.
- run toggled during T1-T3 of sub R0,R7 (iin=16'h6380) -> sequence unaffected; exactly one done; reg_wr=8'h01 in T3.
- Preload retired near 16'hFFFF, then two mv instructions (iin=16'h0000) -> retired goes 16'hFFFF -> 16'h0000.

Source files
------------

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: multi-cycle T0..T3 controller for the 16-bit register/ALU datapath.
// Latches the instruction field on fetch and decodes datapath enables per state and opcode.
module instruction_sequencer #(
    parameter int NREGS = 8,
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             run,
    input  logic [WIDTH-1:0] iin,
    output logic [8:0]       ir,
    output logic [NREGS-1:0] reg_wr,
    output logic [3:0]       mux_sel,
    output logic             ext_en,
    output logic             a_load,
    output logic             g_load,
    output logic [2:0]       alu_op,
    output logic             done,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);
    typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;

    state_t           r_state, w_next;
    logic [8:0]       r_ir;
    logic [CNT_W-1:0] r_retired;
    logic [2:0]       w_op, w_rx, w_ry;
    logic [NREGS-1:0] w_rx_oh;
    logic             w_unused;

    assign w_op     = r_ir[8:6];
    assign w_rx     = r_ir[5:3];
    assign w_ry     = r_ir[2:0];
    assign w_rx_oh  = NREGS'(1) << w_rx;
    assign ir       = r_ir;
    assign retired  = r_retired;
    // Immediate bits go straight to the extensor, not through this block.
    assign w_unused = ^iin[WIDTH-10:0];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_ir      <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && run) r_ir <= iin[WIDTH-1 -: 9];
            if (done && !illegal) r_retired <= r_retired + CNT_W'(1);
        end
    end

    always_comb begin
        w_next  = r_state;
        reg_wr  = '0;
        mux_sel = 4'd15;
        ext_en  = 1'b0;
        a_load  = 1'b0;
        g_load  = 1'b0;
        alu_op  = 3'd0;
        done    = 1'b0;
        illegal = 1'b0;
        case (r_state)
            IDLE: begin
                ext_en = run;
                w_next = run ? T1 : IDLE;
            end
            T1: begin
                case (w_op)
                    3'b000: begin
                        mux_sel = {1'b0, w_ry};
                        reg_wr  = w_rx_oh;
                        done    = 1'b1;
                        w_next  = IDLE;
                    end
                    3'b001: begin
                        mux_sel = 4'd8;
                        reg_wr  = w_rx_oh;
                        done    = 1'b1;
                        w_next  = IDLE;
                    end
                    3'b111: begin
                        done    = 1'b1;
                        illegal = 1'b1;
                        w_next  = IDLE;
                    end
                    default: begin
                        mux_sel = {1'b0, w_rx};
                        a_load  = 1'b1;
                        w_next  = T2;
                    end
                endcase
            end
            T2: begin
                mux_sel = {1'b0, w_ry};
                alu_op  = w_op;
                g_load  = 1'b1;
                w_next  = T3;
            end
            default: begin
                mux_sel = 4'd9;
                reg_wr  = w_rx_oh;
                done    = 1'b1;
                w_next  = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer: random and directed instruction streams checked against
// a per-instruction model of latency, operand selection, register write and retire count.
module tb_instruction_sequencer;
    localparam int CW = 8;

    logic          clock = 1'b0, resetn = 1'b0, run = 1'b0;
    logic [15:0]   iin = '0;
    logic [8:0]    ir;
    logic [7:0]    reg_wr;
    logic [3:0]    mux_sel;
    logic          ext_en, a_load, g_load, done, illegal;
    logic [2:0]    alu_op;
    logic [CW-1:0] retired;

    int n_chk = 0, n_err = 0, exp_ret = 0;
    bit wrapped = 0;

    instruction_sequencer #(.NREGS(8), .WIDTH(16), .CNT_W(CW)) dut (
        .clock(clock), .resetn(resetn), .run(run), .iin(iin), .ir(ir),
        .reg_wr(reg_wr), .mux_sel(mux_sel), .ext_en(ext_en), .a_load(a_load),
        .g_load(g_load), .alu_op(alu_op), .done(done), .illegal(illegal),
        .retired(retired)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Operand routed to the bus on each step of an instruction's execution.
    function automatic logic [3:0] exp_mux(input logic [2:0] op, rx, ry, input int step);
        if (op == 3'd0) return {1'b0, ry};
        if (op == 3'd1) return 4'd8;
        if (op == 3'd7) return 4'd15;
        return step == 1 ? {1'b0, rx} : step == 2 ? {1'b0, ry} : 4'd9;
    endfunction

    // mode 0: run pulse, 1: run held high, 2: run/iin scrambled after fetch
    task automatic do_instr(input logic [15:0] w, input int mode);
        logic [2:0] op, rx, ry;
        bit alu, ill, dn, ill_seen;
        int lat, writes, aloads, gloads;
        logic [7:0] wr_done;
        op = w[15:13]; rx = w[12:10]; ry = w[9:7];
        alu = op >= 3'd2 && op <= 3'd6;
        ill = op == 3'd7;
        dn = 0; ill_seen = 0; lat = 1; writes = 0; aloads = 0; gloads = 0; wr_done = '0;
        @(negedge clock);
        chk("retired", retired, exp_ret);
        run = 1'b1;
        iin = w;
        #1 chk("ext_en", ext_en, 1);
        while (!dn && lat < 8) begin
            @(negedge clock);
            lat++;
            if (lat == 2) chk("ir", ir, w[15:7]);
            chk("mux_sel", mux_sel, exp_mux(op, rx, ry, lat - 1));
            chk("onehot", $countones(reg_wr) <= 1, 1);
            writes += $countones(reg_wr);
            aloads += a_load;
            gloads += g_load;
            if (g_load) chk("alu_op", alu_op, op);
            if (done) begin
                dn = 1;
                wr_done = reg_wr;
                ill_seen = illegal;
            end
            if (mode == 2) begin
                run = 1'($urandom_range(1));
                iin = 16'($urandom);
            end else if (mode == 0) run = 1'b0;
        end
        chk("latency", lat, alu ? 4 : 2);
        chk("wr_at_done", wr_done, ill ? 8'h00 : 8'h01 << rx);
        chk("illegal", ill_seen, ill);
        chk("writes", writes, ill ? 0 : 1);
        chk("a_loads", aloads, alu);
        chk("g_loads", gloads, alu);
        if (!ill) begin
            exp_ret = (exp_ret + 1) % (1 << CW);
            if (exp_ret == 0) wrapped = 1;
        end
    endtask

    initial begin
        int dones;
        #1;
        chk("rst_mux", mux_sel, 4'd15);
        chk("rst_outs", {reg_wr, ext_en, a_load, g_load, done, illegal, alu_op}, 0);
        chk("rst_state", {ir, retired}, 0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        #1 chk("idle", {reg_wr, ext_en, a_load, g_load, done, illegal}, 0);

        do_instr(16'h3405, 0);
        do_instr(16'h4500, 1);
        do_instr(16'hE000, 1);
        do_instr(16'h6380, 2);
        do_instr(16'h0D80, 0);
        do_instr(16'h4900, 0);

        // abort an add in T2 with an asynchronous reset
        @(negedge clock);
        run = 1'b1;
        iin = 16'h4500;
        @(negedge clock);
        run = 1'b0;
        @(negedge clock);
        chk("pre_rst_g", g_load, 1);
        #2 resetn = 1'b0;
        #1;
        chk("arst_mux", mux_sel, 4'd15);
        chk("arst_wr", {reg_wr, done, g_load}, 0);
        chk("arst_ret", retired, 0);
        exp_ret = 0;
        @(negedge clock);
        resetn = 1'b1;
        dones = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            dones += done;
        end
        chk("no_done_after_rst", dones, 0);

        for (int n = 0; n < 400; n++) do_instr(16'($urandom), int'($urandom_range(2)));
        @(negedge clock);
        run = 1'b0;
        chk("retired_end", retired, exp_ret);
        chk("wrap_seen", wrapped, 1);
        @(negedge clock);
        chk("idle_end", {reg_wr, ext_en, a_load, g_load, done, illegal}, 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
